drac_l15_req_arbiter: RTL and testbench
=======================================

Name: drac_l15_req_arbiter

Overview:
Request-side arbiter and output stage that merges the core tile's memory request ports (I$ miss, D$ miss, D$ write-buffer, uncached read, uncached write, AMO) into the single request stream consumed by the L1.5 request encoder. It applies fixed priority (port 0 highest) and holds the grant for multi-beat transactions. It limits in-flight transactions with a credit counter and registers the winning beat in a one-entry output buffer.

Parameters:
NUM_PORTS, 6, number of request ports; port 0 has highest priority.
PAYLOAD_W, 128, width of one request beat.
MAX_OUTSTANDING, 4, maximum transactions issued and not yet returned; must be at least 1.
STARVE_TH, 16, wait-cycle threshold for anti-starvation; used only when the feature is compiled in.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
req_valid_i  in  NUM_PORTS  per-port beat valid
req_ready_o  out  NUM_PORTS  per-port beat accepted
req_last_i  in  NUM_PORTS  beat is the final beat of its transaction
req_payload_i  in  NUM_PORTS*PAYLOAD_W  per-port beat; port p occupies bits [p*PAYLOAD_W +: PAYLOAD_W]
out_valid_o  out  1  output buffer holds a beat
out_ready_i  in  1  downstream accepts the beat
out_payload_o  out  PAYLOAD_W  buffered beat
out_portid_o  out  $clog2(NUM_PORTS)  source port of the buffered beat
out_last_o  out  1  buffered beat is the last beat of its transaction
rtrn_done_i  in  1  one pulse per completed L1.5 return; frees one credit
credits_o  out  $clog2(MAX_OUTSTANDING+1)  credits currently available
busy_o  out  1  FSM not in IDLE, or out_valid_o is high

Behaviour:
- Reset values: out_valid_o=0, out_payload_o=0, out_portid_o=0, out_last_o=0, req_ready_o=0, credits_o=MAX_OUTSTANDING, busy_o=0, FSM=IDLE. Reset is legal in any state: any in-flight beat or transaction is dropped with no flush.
- Buffer free condition: out_free = !out_valid_o | out_ready_i. A beat that downstream accepts in cycle N can be replaced by a new beat in the same cycle.
- FSM states:
  - IDLE: if out_free, credits>0, and any req_valid_i is high, grant the winner (lowest index among valid ports). Assert req_ready_o[winner] in the same cycle (combinational). Load the buffer on the next edge. Consume one credit.
  - IDLE transitions: if the winner's req_last_i=0, go to LOCKED and store gnt_q=winner; otherwise stay in IDLE.
  - LOCKED: only port gnt_q can be granted; credits are neither checked nor consumed. req_ready_o[gnt_q] = out_free. When a beat with req_last_i=1 is accepted, return to IDLE. Higher-priority valid ports wait.
- Latency: a granted beat appears on out_valid_o one cycle after its req handshake.
- Back-to-back: with out_ready_i held at 1, sustained throughput is one beat per cycle.
- Credits:
  - Decrement on each transaction start (first beat granted in IDLE).
  - Increment on rtrn_done_i.
  - If both happen in the same cycle, the count is unchanged.
  - credits_o==0 blocks new grants in IDLE only.
  - rtrn_done_i while credits==MAX_OUTSTANDING is ignored (saturates); an assertion flags it in simulation.
- req_ready_o is zero for every port that is not granted. It is never high for a port whose req_valid_i is low.
- Payload and portid are stable while out_valid_o=1 and out_ready_i=0.

Optional Feature:
DRAC_ARB_ANTI_STARVE_EN
- Compiled in:
  - Each port has a saturating wait counter of $clog2(STARVE_TH+1) bits.
  - The counter increments each cycle the port is valid but not granted in IDLE, and clears when the port is granted.
  - A port is starved when its counter has reached STARVE_TH.
  - In IDLE, starved ports take precedence over fixed priority; the lowest-index starved port wins.
  - Counters hold their value while in LOCKED.
- Compiled out: pure fixed priority; no counters are instantiated.

Test Plan:
- Ports 0 and 3 valid in the same cycle, both single-beat, out_ready_i=1 → port 0 appears on out first (portid 0), port 3 one cycle later (portid 3); credits 4→3→2.
- Port 2 issues 3 beats (last on beat 3); port 0 becomes valid after beat 1 → out_portid_o stays 2 for all 3 beats; port 0 is granted in the cycle after the last beat is accepted.
- Four single-beat transactions with no rtrn_done_i → credits_o=0; a fifth request waits. One rtrn_done_i pulse → credits_o=1 and the fifth beat is granted the next cycle.
- out_ready_i=0 for 5 cycles with a beat buffered → out_payload_o is unchanged and req_ready_o=0 on all ports. On release, the next beat follows immediately.
- Grant and rtrn_done_i in the same cycle at credits=2 → credits stays 2.
- With DRAC_ARB_ANTI_STARVE_EN and STARVE_TH=16: port 0 is continuously valid and port 5 is valid → port 5 is granted on or before its 17th waiting IDLE grant slot. Without the macro, port 5 is never granted.
- rst_ni asserted while in LOCKED with out_valid_o=1 → all outputs return to reset values asynchronously; after release, the FSM is in IDLE and credits=MAX_OUTSTANDING.

Source files
------------

// File: rtl/drac_l15_req_arbiter_if.sv
// rtl/drac_l15_req_arbiter_if.sv - request and output stream bundle for the L1.5 request arbiter
interface drac_l15_req_arbiter_if #(
    parameter int NUM_PORTS = 6,
    parameter int PAYLOAD_W = 128
);
    localparam int PID_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    logic [NUM_PORTS-1:0]           req_valid_i;
    logic [NUM_PORTS-1:0]           req_ready_o;
    logic [NUM_PORTS-1:0]           req_last_i;
    logic [NUM_PORTS*PAYLOAD_W-1:0] req_payload_i;
    logic                           out_valid_o;
    logic                           out_ready_i;
    logic [PAYLOAD_W-1:0]           out_payload_o;
    logic [PID_W-1:0]               out_portid_o;
    logic                           out_last_o;

    // arbiter side
    modport slave (
        input  req_valid_i, req_last_i, req_payload_i, out_ready_i,
        output req_ready_o, out_valid_o, out_payload_o, out_portid_o, out_last_o
    );

    // requesters plus downstream encoder side
    modport master (
        output req_valid_i, req_last_i, req_payload_i, out_ready_i,
        input  req_ready_o, out_valid_o, out_payload_o, out_portid_o, out_last_o
    );
endinterface

// File: rtl/drac_l15_req_arbiter.sv
// rtl/drac_l15_req_arbiter.sv - fixed-priority request arbiter with grant lock, credits and output buffer (optional DRAC_ARB_ANTI_STARVE_EN)
module drac_l15_req_arbiter #(
    parameter int NUM_PORTS       = 6,
    parameter int PAYLOAD_W       = 128,
    parameter int MAX_OUTSTANDING = 4,
    parameter int STARVE_TH       = 16
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    drac_l15_req_arbiter_if.slave                 bus,
    input  logic                                  rtrn_done_i,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]  credits_o,
    output logic                                  busy_o
);
    localparam int PID_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int CRD_W = $clog2(MAX_OUTSTANDING+1);

    if (MAX_OUTSTANDING < 1 || STARVE_TH < 1) begin : g_bad_cfg
        $error("drac_l15_req_arbiter: MAX_OUTSTANDING and STARVE_TH must be at least 1");
    end

    typedef enum logic [0:0] {ST_IDLE, ST_LOCKED} state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [PID_W-1:0]     r_gnt_q;
    logic [CRD_W-1:0]     r_credits;
    logic                 r_out_valid;
    logic [PAYLOAD_W-1:0] r_out_payload;
    logic [PID_W-1:0]     r_out_portid;
    logic                 r_out_last;

    logic                 w_out_free;
    logic                 w_any_valid;
    logic [PID_W-1:0]     w_fixed_idx;
    logic [PID_W-1:0]     w_winner;
    logic                 w_grant;
    logic                 w_start;
    logic [PID_W-1:0]     w_gnt_idx;
    logic [NUM_PORTS-1:0] w_ready;
    logic [PAYLOAD_W-1:0] w_sel_payload;
    logic                 w_rtrn_eff;

    assign w_out_free  = !r_out_valid || bus.out_ready_i;
    assign w_any_valid = |bus.req_valid_i;

    // lowest-index valid port wins under plain fixed priority
    always_comb begin
        w_fixed_idx = '0;
        for (int p = NUM_PORTS-1; p >= 0; p--) begin
            if (bus.req_valid_i[p]) w_fixed_idx = PID_W'(p);
        end
    end

`ifdef DRAC_ARB_ANTI_STARVE_EN
    localparam int SW = $clog2(STARVE_TH+1);

    logic [SW-1:0]        r_wait [NUM_PORTS];
    logic [NUM_PORTS-1:0] w_starved;
    logic [PID_W-1:0]     w_starve_idx;

    // a valid port whose wait count hit the threshold overrides fixed priority
    always_comb begin
        w_starve_idx = '0;
        for (int p = NUM_PORTS-1; p >= 0; p--) begin
            w_starved[p] = bus.req_valid_i[p] && (r_wait[p] == SW'(STARVE_TH));
            if (w_starved[p]) w_starve_idx = PID_W'(p);
        end
    end

    assign w_winner = (|w_starved) ? w_starve_idx : w_fixed_idx;

    // wait counters advance only in IDLE; a grant clears, LOCKED holds
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int p = 0; p < NUM_PORTS; p++) r_wait[p] <= '0;
        end else if (r_state == ST_IDLE) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (w_grant && (w_gnt_idx == PID_W'(p))) begin
                    r_wait[p] <= '0;
                end else if (bus.req_valid_i[p] && (r_wait[p] != SW'(STARVE_TH))) begin
                    r_wait[p] <= r_wait[p] + SW'(1);
                end
            end
        end
    end
`else
    assign w_winner = w_fixed_idx;
`endif

    // next state and grant decision; LOCKED ignores credits and other ports
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_start     = 1'b0;
        w_gnt_idx   = r_gnt_q;
        w_ready     = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_out_free && (r_credits != '0) && w_any_valid) begin
                    w_grant            = 1'b1;
                    w_start            = 1'b1;
                    w_gnt_idx          = w_winner;
                    w_ready[w_winner]  = 1'b1;
                    if (!bus.req_last_i[w_winner]) w_state_nxt = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (w_out_free && bus.req_valid_i[r_gnt_q]) begin
                    w_grant           = 1'b1;
                    w_ready[r_gnt_q]  = 1'b1;
                    if (bus.req_last_i[r_gnt_q]) w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // payload mux for the granted port
    always_comb begin
        w_sel_payload = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (w_gnt_idx == PID_W'(p)) w_sel_payload = bus.req_payload_i[p*PAYLOAD_W +: PAYLOAD_W];
        end
    end

    // FSM state and locked port
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
            r_gnt_q <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start) r_gnt_q <= w_gnt_idx;
        end
    end

    // returns at full credit are dropped so the counter saturates
    assign w_rtrn_eff = rtrn_done_i && (r_credits != CRD_W'(MAX_OUTSTANDING));

    // credit counter: start consumes, return frees, both together cancel
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_credits <= CRD_W'(MAX_OUTSTANDING);
        end else if (w_start && !w_rtrn_eff) begin
            r_credits <= r_credits - CRD_W'(1);
        end else if (!w_start && w_rtrn_eff) begin
            r_credits <= r_credits + CRD_W'(1);
        end
    end

    // one-entry output buffer; reloads in the same cycle it drains
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_out_valid   <= 1'b0;
            r_out_payload <= '0;
            r_out_portid  <= '0;
            r_out_last    <= 1'b0;
        end else if (w_grant) begin
            r_out_valid   <= 1'b1;
            r_out_payload <= w_sel_payload;
            r_out_portid  <= w_gnt_idx;
            r_out_last    <= bus.req_last_i[w_gnt_idx];
        end else if (bus.out_ready_i) begin
            r_out_valid   <= 1'b0;
        end
    end

    // a return pulse with every credit already free indicates a protocol error upstream
    a_rtrn_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(rtrn_done_i && (r_credits == CRD_W'(MAX_OUTSTANDING))));

    assign bus.req_ready_o   = w_ready & {NUM_PORTS{rst_ni}};
    assign bus.out_valid_o   = r_out_valid;
    assign bus.out_payload_o = r_out_payload;
    assign bus.out_portid_o  = r_out_portid;
    assign bus.out_last_o    = r_out_last;
    assign credits_o         = r_credits;
    assign busy_o            = (r_state != ST_IDLE) || r_out_valid;
endmodule

// File: tb/tb_drac_l15_req_arbiter.sv
// tb/tb_drac_l15_req_arbiter.sv - directed self-checking bench for drac_l15_req_arbiter
module tb_drac_l15_req_arbiter;
    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       rtrn_done_i;
    logic [2:0] credits_o;
    logic       busy_o;
    int         n_cmp = 0;
    int         n_err = 0;
    int         first5;

    drac_l15_req_arbiter_if #(.NUM_PORTS(6), .PAYLOAD_W(128)) bus ();

    drac_l15_req_arbiter #(
        .NUM_PORTS(6), .PAYLOAD_W(128), .MAX_OUTSTANDING(4), .STARVE_TH(16)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .bus         (bus),
        .rtrn_done_i (rtrn_done_i),
        .credits_o   (credits_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [127:0] pl(input int p, input int b);
        return {96'h0, 16'hC0DE, 8'(p), 8'(b)};
    endfunction

    task automatic set_req(input int p, input logic v, input logic l, input logic [127:0] d);
        bus.req_valid_i[p]               = v;
        bus.req_last_i[p]                = l;
        bus.req_payload_i[p*128 +: 128]  = d;
    endtask

    initial begin
        rst_ni            = 1'b0;
        rtrn_done_i       = 1'b0;
        bus.req_valid_i   = '0;
        bus.req_last_i    = '0;
        bus.req_payload_i = '0;
        bus.out_ready_i   = 1'b0;
        step();
        step();
        chk("rst_out_valid", bus.out_valid_o, 0);
        chk("rst_payload", bus.out_payload_o, 0);
        chk("rst_portid", bus.out_portid_o, 0);
        chk("rst_last", bus.out_last_o, 0);
        chk("rst_ready", bus.req_ready_o, 0);
        chk("rst_credits", credits_o, 4);
        chk("rst_busy", busy_o, 0);
        rst_ni = 1'b1;

        // fixed priority: port 0 then port 3
        bus.out_ready_i = 1'b1;
        set_req(0, 1, 1, pl(0, 0));
        set_req(3, 1, 1, pl(3, 0));
        #1 chk("pri_ready0", bus.req_ready_o, 6'h01);
        chk("pri_cred4", credits_o, 4);
        step();
        set_req(0, 0, 0, '0);
        #1 chk("pri_port0", bus.out_portid_o, 0);
        chk("pri_pay0", bus.out_payload_o, pl(0, 0));
        chk("pri_cred3", credits_o, 3);
        chk("pri_ready3", bus.req_ready_o, 6'h08);
        step();
        set_req(3, 0, 0, '0);
        #1 chk("pri_port3", bus.out_portid_o, 3);
        chk("pri_cred2", credits_o, 2);
        step();
        chk("pri_drained", bus.out_valid_o, 0);
        chk("pri_idle", busy_o, 0);
        rtrn_done_i = 1'b1;
        step();
        step();
        rtrn_done_i = 1'b0;
        chk("pri_refill", credits_o, 4);

        // multi-beat lock on port 2, port 0 waits
        set_req(2, 1, 0, pl(2, 1));
        #1 chk("lock_b1_ready", bus.req_ready_o, 6'h04);
        step();
        set_req(2, 1, 0, pl(2, 2));
        set_req(0, 1, 1, pl(0, 5));
        #1 chk("lock_b2_ready", bus.req_ready_o, 6'h04);
        chk("lock_b1_port", bus.out_portid_o, 2);
        chk("lock_b1_pay", bus.out_payload_o, pl(2, 1));
        chk("lock_busy", busy_o, 1);
        step();
        set_req(2, 1, 1, pl(2, 3));
        #1 chk("lock_b3_ready", bus.req_ready_o, 6'h04);
        chk("lock_b2_pay", bus.out_payload_o, pl(2, 2));
        chk("lock_b2_last", bus.out_last_o, 0);
        step();
        set_req(2, 0, 0, '0);
        #1 chk("lock_b3_port", bus.out_portid_o, 2);
        chk("lock_b3_last", bus.out_last_o, 1);
        chk("lock_p0_ready", bus.req_ready_o, 6'h01);
        step();
        set_req(0, 0, 0, '0);
        #1 chk("lock_p0_port", bus.out_portid_o, 0);
        chk("lock_cred", credits_o, 2);
        step();

        // grant and return in the same cycle at credits=2
        set_req(1, 1, 1, pl(1, 7));
        rtrn_done_i = 1'b1;
        #1 chk("same_ready", bus.req_ready_o, 6'h02);
        step();
        set_req(1, 0, 0, '0);
        rtrn_done_i = 1'b0;
        #1 chk("same_cred", credits_o, 2);
        chk("same_port", bus.out_portid_o, 1);
        step();
        rtrn_done_i = 1'b1;
        step();
        step();
        rtrn_done_i = 1'b0;
        chk("same_refill", credits_o, 4);

        // credit exhaustion and release
        for (int i = 0; i < 4; i++) begin
            set_req(4, 1, 1, pl(4, i));
            step();
        end
        #1 chk("crd_zero", credits_o, 0);
        chk("crd_block", bus.req_ready_o, 0);
        step();
        chk("crd_drained", bus.out_valid_o, 0);
        chk("crd_still_block", bus.req_ready_o, 0);
        rtrn_done_i = 1'b1;
        #1 chk("crd_rtrn_block", bus.req_ready_o, 0);
        step();
        rtrn_done_i = 1'b0;
        set_req(4, 1, 1, pl(4, 4));
        #1 chk("crd_one", credits_o, 1);
        chk("crd_fifth_ready", bus.req_ready_o, 6'h10);
        step();
        set_req(4, 0, 0, '0);
        chk("crd_fifth_out", bus.out_payload_o, pl(4, 4));
        chk("crd_zero_again", credits_o, 0);
        step();
        rtrn_done_i = 1'b1;
        for (int i = 0; i < 4; i++) step();
        rtrn_done_i = 1'b0;
        chk("crd_refill", credits_o, 4);

        // downstream stall holds the buffered beat
        bus.out_ready_i = 1'b0;
        set_req(1, 1, 1, pl(1, 1));
        step();
        set_req(1, 1, 1, pl(1, 2));
        for (int i = 0; i < 5; i++) begin
            #1 chk("stall_pay", bus.out_payload_o, pl(1, 1));
            chk("stall_ready", bus.req_ready_o, 0);
            step();
        end
        bus.out_ready_i = 1'b1;
        #1 chk("stall_release_ready", bus.req_ready_o, 6'h02);
        step();
        set_req(1, 0, 0, '0);
        #1 chk("stall_next_pay", bus.out_payload_o, pl(1, 2));
        step();
        rtrn_done_i = 1'b1;
        step();
        step();
        rtrn_done_i = 1'b0;
        chk("stall_refill", credits_o, 4);

        // port 0 hogging versus port 5
        first5 = 0;
        set_req(0, 1, 1, pl(0, 9));
        set_req(5, 1, 1, pl(5, 9));
        for (int c = 1; c <= 40; c++) begin
            rtrn_done_i = (credits_o < 3'd4);
            #1;
            if (bus.req_ready_o[5] && first5 == 0) first5 = c;
            step();
        end
        rtrn_done_i = 1'b0;
        set_req(0, 0, 0, '0);
        set_req(5, 0, 0, '0);
`ifdef DRAC_ARB_ANTI_STARVE_EN
        chk("starve_on_p5", (first5 >= 1 && first5 <= 17), 1);
`else
        chk("starve_off_p5", first5, 0);
`endif
        step();
        for (int i = 0; i < 8; i++) begin
            if (credits_o < 3'd4) begin
                rtrn_done_i = 1'b1;
                step();
                rtrn_done_i = 1'b0;
            end
        end
        chk("starve_refill", credits_o, 4);

        // asynchronous reset while LOCKED with a buffered beat
        set_req(2, 1, 0, pl(2, 9));
        step();
        #1 chk("arst_pre_busy", busy_o, 1);
        chk("arst_pre_valid", bus.out_valid_o, 1);
        #1 rst_ni = 1'b0;
        #1 chk("arst_valid", bus.out_valid_o, 0);
        chk("arst_pay", bus.out_payload_o, 0);
        chk("arst_portid", bus.out_portid_o, 0);
        chk("arst_ready", bus.req_ready_o, 0);
        chk("arst_credits", credits_o, 4);
        chk("arst_busy", busy_o, 0);
        set_req(2, 0, 0, '0);
        step();
        rst_ni = 1'b1;
        set_req(3, 1, 1, pl(3, 1));
        #1 chk("arst_idle_ready", bus.req_ready_o, 6'h08);
        step();
        set_req(3, 0, 0, '0);
        #1 chk("arst_idle_port", bus.out_portid_o, 3);
        chk("arst_idle_cred", credits_o, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
